// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the IF/MEM sram-like port arbiter.
// Owner tags, arbiter state codes and the forwarded command bundle.
package sram_req_arbiter_pkg;

    typedef logic [1:0] sram_size_t;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_HOLD_I = 2'd1,
        ARB_HOLD_D = 2'd2
    } arb_state_e;

    typedef enum logic {
        TAG_INST = 1'b0,
        TAG_DATA = 1'b1
    } tag_e;

    localparam sram_size_t SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        sram_size_t  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } sram_cmd_t;

    // Instruction fetch is always a word read.
    function automatic sram_cmd_t inst_cmd(input logic [31:0] addr);
        sram_cmd_t c;
        c.wr    = 1'b0;
        c.size  = SIZE_WORD;
        c.wstrb = 4'b0000;
        c.addr  = addr;
        c.wdata = 32'h0;
        return c;
    endfunction

endpackage

// File: rtl/sram_req_arbiter_if.sv
// Sram-like request/response port: master issues req, slave answers.
// Used for the inst side, the data side and the shared memory side.
interface sram_req_arbiter_if;
    import sram_req_arbiter_pkg::*;

    logic        req;
    logic        wr;
    sram_size_t  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req,
        output wr,
        output size,
        output wstrb,
        output addr,
        output wdata,
        input  addr_ok,
        input  data_ok,
        input  rdata
    );

    modport slave (
        input  req,
        input  wr,
        input  size,
        input  wstrb,
        input  addr,
        input  wdata,
        output addr_ok,
        output data_ok,
        output rdata
    );

endinterface

// File: rtl/sram_req_arbiter_tag_fifo.sv
// In-order owner-tag FIFO for accepted, not yet answered transactions.
// Push and pop may coincide at any occupancy, including full.
module sram_req_arbiter_tag_fifo
    import sram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push_i,
    input  logic pop_i,
    input  tag_e tag_i,
    output tag_e tag_o,
    output logic full_o,
    output logic empty_o
);

    localparam int AW = $clog2(DEPTH);

    tag_e           mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    cnt_q, cnt_d;
    logic           do_push;
    logic           do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign tag_o   = mem_q[rptr_q];

    // Pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q] <= tag_i;
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one sram-like port between instruction fetch (M0) and data (M1).
// Data has priority; a starve counter eventually forces an M0 grant.
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING = 4,
    parameter int STARVE_MAX  = 8
) (
    input  logic             clk,
    input  logic             reset,
    sram_req_arbiter_if.slave  inst_io,
    sram_req_arbiter_if.slave  data_io,
    sram_req_arbiter_if.master mem_io
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    arb_state_e    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;

    logic      fifo_full;
    logic      fifo_empty;
    logic      pop;
    logic      room;
    logic      gnt_i;
    logic      gnt_d;
    logic      m_req;
    logic      accept;
    tag_e      head_tag;
    tag_e      push_tag;
    sram_cmd_t i_cmd;
    sram_cmd_t d_cmd;
    sram_cmd_t m_cmd;
    logic      inst_unused;

    assign inst_unused = ^{inst_io.wr, inst_io.size,
                           inst_io.wstrb, inst_io.wdata};

    assign i_cmd = inst_cmd(inst_io.addr);
    assign d_cmd = '{wr:    data_io.wr,
                     size:  data_io.size,
                     wstrb: data_io.wstrb,
                     addr:  data_io.addr,
                     wdata: data_io.wdata};

    // A response in the same cycle frees a slot for a new accept.
    assign pop  = !reset && mem_io.data_ok && !fifo_empty;
    assign room = !fifo_full || pop;

    always_comb begin
        state_d = state_q;
        gnt_i   = 1'b0;
        gnt_d   = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (room) begin
                    if (inst_io.req &&
                        (!data_io.req || starve_q == STARVE_LIM)) begin
                        gnt_i = 1'b1;
                    end else begin
                        gnt_d = data_io.req;
                    end
                end
            end
            ARB_HOLD_I: gnt_i = 1'b1;
            ARB_HOLD_D: gnt_d = 1'b1;
            default: ;
        endcase
        if (reset) begin
            gnt_i = 1'b0;
            gnt_d = 1'b0;
        end
        if ((gnt_i || gnt_d) && !mem_io.addr_ok) begin
            state_d = gnt_i ? ARB_HOLD_I : ARB_HOLD_D;
        end else begin
            state_d = ARB_IDLE;
        end
    end

    always_comb begin
        starve_d = starve_q;
        if (!inst_io.req || (gnt_i && mem_io.addr_ok)) begin
            starve_d = '0;
        end else if (starve_q != STARVE_LIM) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ARB_IDLE;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        m_cmd = '0;
        if (gnt_i) begin
            m_cmd = i_cmd;
        end else if (gnt_d) begin
            m_cmd = d_cmd;
        end
    end

    assign m_req    = gnt_i || gnt_d;
    assign accept   = m_req && mem_io.addr_ok;
    assign push_tag = gnt_d ? TAG_DATA : TAG_INST;

    assign mem_io.req   = m_req;
    assign mem_io.wr    = m_cmd.wr;
    assign mem_io.size  = m_cmd.size;
    assign mem_io.wstrb = m_cmd.wstrb;
    assign mem_io.addr  = m_cmd.addr;
    assign mem_io.wdata = m_cmd.wdata;

    assign inst_io.addr_ok = gnt_i && mem_io.addr_ok;
    assign data_io.addr_ok = gnt_d && mem_io.addr_ok;

    assign inst_io.data_ok = pop && (head_tag == TAG_INST);
    assign data_io.data_ok = pop && (head_tag == TAG_DATA);
    assign inst_io.rdata   = inst_io.data_ok ? mem_io.rdata : 32'h0;
    assign data_io.rdata   = data_io.data_ok ? mem_io.rdata : 32'h0;

    sram_req_arbiter_tag_fifo #(
        .DEPTH (OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (pop),
        .tag_i   (push_tag),
        .tag_o   (head_tag),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    a_no_orphan_resp: assert property (
        @(posedge clk) disable iff (reset)
        !(mem_io.data_ok && fifo_empty)
    );

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Bench for sram_req_arbiter: directed vector table, corner sequences,
// then random traffic against a queue-based reference model.
module tb_sram_req_arbiter;
    import sram_req_arbiter_pkg::*;

    localparam int OUT  = 4;
    localparam int SMAX = 8;
    localparam logic [31:0] DW = 32'h5555aaaa;

    typedef struct packed {
        logic        mreq;
        logic        mwr;
        logic [1:0]  msize;
        logic [3:0]  mwstrb;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic        iaok;
        logic        idok;
        logic [31:0] irdata;
        logic        daok;
        logic        ddok;
        logic [31:0] drdata;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic        dwr;
        logic [1:0]  dsize;
        logic [3:0]  dstrb;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        maok;
        logic        mdok;
        logic [31:0] mrdata;
    } in_t;

    typedef struct {
        in_t  i;
        out_t e;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    sram_req_arbiter_if inst_if ();
    sram_req_arbiter_if data_if ();
    sram_req_arbiter_if mem_if ();

    sram_req_arbiter #(
        .OUTSTANDING (OUT),
        .STARVE_MAX  (SMAX)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .inst_io (inst_if.slave),
        .data_io (data_if.slave),
        .mem_io  (mem_if.master)
    );

    function automatic in_t vi(logic rst, logic ireq, logic [31:0] iaddr,
                               logic dreq, logic dwr, logic [3:0] dstrb,
                               logic [31:0] daddr, logic maok, logic mdok,
                               logic [31:0] mrdata);
        in_t v;
        v.rst = rst;     v.ireq = ireq;   v.iaddr = iaddr;
        v.dreq = dreq;   v.dwr = dwr;     v.dsize = 2'd2;
        v.dstrb = dstrb; v.daddr = daddr; v.dwdata = DW;
        v.maok = maok;   v.mdok = mdok;   v.mrdata = mrdata;
        return v;
    endfunction

    function automatic out_t vo(logic mreq, logic mwr, logic [3:0] mwstrb,
                                logic [31:0] maddr, logic iaok, logic daok,
                                logic idok, logic [31:0] irdata,
                                logic ddok, logic [31:0] drdata);
        out_t o;
        o.mreq = mreq;  o.mwr = mwr;   o.msize = 2'd2;
        o.mwstrb = mwstrb; o.maddr = maddr;
        o.mwdata = mwr ? DW : 32'h0;
        o.iaok = iaok;  o.idok = idok; o.irdata = irdata;
        o.daok = daok;  o.ddok = ddok; o.drdata = drdata;
        return o;
    endfunction

    task automatic apply(input in_t v);
        reset         = v.rst;
        inst_if.req   = v.ireq;
        inst_if.addr  = v.iaddr;
        inst_if.wr    = 1'b0;
        inst_if.size  = 2'd2;
        inst_if.wstrb = 4'h0;
        inst_if.wdata = 32'h0;
        data_if.req   = v.dreq;
        data_if.wr    = v.dwr;
        data_if.size  = v.dsize;
        data_if.wstrb = v.dstrb;
        data_if.addr  = v.daddr;
        data_if.wdata = v.dwdata;
        mem_if.addr_ok = v.maok;
        mem_if.data_ok = v.mdok;
        mem_if.rdata   = v.mrdata;
    endtask

    function automatic out_t sample();
        out_t o;
        o.mreq = mem_if.req;     o.mwr = mem_if.wr;
        o.msize = mem_if.size;   o.mwstrb = mem_if.wstrb;
        o.maddr = mem_if.addr;   o.mwdata = mem_if.wdata;
        o.iaok = inst_if.addr_ok; o.idok = inst_if.data_ok;
        o.irdata = inst_if.rdata;
        o.daok = data_if.addr_ok; o.ddok = data_if.data_ok;
        o.drdata = data_if.rdata;
        return o;
    endfunction

    // Request payload is only meaningful while m_req is high.
    function automatic out_t mask(out_t o, logic keep);
        if (!keep) begin
            o.mwr = 1'b0; o.msize = 2'd0; o.mwstrb = 4'h0;
            o.maddr = 32'h0; o.mwdata = 32'h0;
        end
        return o;
    endfunction

    task automatic check(input string nm, input out_t a, input out_t e);
        out_t am, em;
        am = mask(a, e.mreq);
        em = mask(e, e.mreq);
        n_cmp++;
        if (am !== em) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, am, em);
        end
    endtask

    task automatic check1(input string nm, input logic [127:0] a,
                          input logic [127:0] e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic cyc(input in_t v, output out_t o);
        apply(v);
        @(negedge clk);
        o = sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[13];
        out_t o;
        in_t  idle;
        int   first_i;
        logic d_after;
        logic all_ok;
        int   q[$];
        int   held, starve, win;
        bit   pop, room;
        logic ip, dp, dwr_r;
        logic [31:0] ia, da, dd;
        logic [1:0]  ds;
        logic [3:0]  dst;

        idle = vi(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        tbl[0]  = '{vi(1, 1, 32'h1c000000, 0, 0, 0, 0, 0, 0, 0),
                    vo(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
        tbl[1]  = '{vi(0, 1, 32'h1c000000, 0, 0, 0, 0, 1, 0, 0),
                    vo(1, 0, 0, 32'h1c000000, 1, 0, 0, 0, 0, 0)};
        tbl[2]  = '{vi(0, 0, 0, 0, 0, 0, 0, 1, 1, 32'h02800c0c),
                    vo(0, 0, 0, 0, 0, 0, 1, 32'h02800c0c, 0, 0)};
        tbl[3]  = '{vi(0, 1, 32'h1c000004, 1, 1, 4'b0011, 32'h1c008000,
                       1, 0, 0),
                    vo(1, 1, 4'b0011, 32'h1c008000, 0, 1, 0, 0, 0, 0)};
        tbl[4]  = '{vi(0, 1, 32'h1c000004, 0, 0, 0, 0, 1, 0, 0),
                    vo(1, 0, 0, 32'h1c000004, 1, 0, 0, 0, 0, 0)};
        tbl[5]  = '{vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111),
                    vo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h11111111)};
        tbl[6]  = '{vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h33333333),
                    vo(0, 0, 0, 0, 0, 0, 1, 32'h33333333, 0, 0)};
        tbl[7]  = '{vi(0, 1, 32'h1c000010, 0, 0, 0, 0, 0, 0, 0),
                    vo(1, 0, 0, 32'h1c000010, 0, 0, 0, 0, 0, 0)};
        tbl[8]  = '{vi(0, 1, 32'h1c000010, 1, 1, 4'hf, 32'h1c008004,
                       0, 0, 0),
                    vo(1, 0, 0, 32'h1c000010, 0, 0, 0, 0, 0, 0)};
        tbl[9]  = '{vi(0, 1, 32'h1c000010, 1, 1, 4'hf, 32'h1c008004,
                       1, 0, 0),
                    vo(1, 0, 0, 32'h1c000010, 1, 0, 0, 0, 0, 0)};
        tbl[10] = '{vi(0, 0, 0, 1, 1, 4'hf, 32'h1c008004, 1, 0, 0),
                    vo(1, 1, 4'hf, 32'h1c008004, 0, 1, 0, 0, 0, 0)};
        tbl[11] = '{vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'haaaa0001),
                    vo(0, 0, 0, 0, 0, 0, 1, 32'haaaa0001, 0, 0)};
        tbl[12] = '{vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hbbbb0002),
                    vo(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hbbbb0002)};

        apply(vi(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < 13; k++) begin
            cyc(tbl[k].i, o);
            check($sformatf("vec%0d", k), o, tbl[k].e);
        end

        // Starvation: data requests every cycle, fetch must still win.
        first_i = -1;
        d_after = 1'b0;
        for (int c = 0; c < 13; c++) begin
            cyc(vi(0, 1, 32'h1c000100, 1, 0, 4'h0, 32'h1c008100,
                   1, c > 0, 32'(c)), o);
            if (o.iaok && first_i < 0) first_i = c;
            if (first_i >= 0 && c == first_i + 1) d_after = o.daok;
        end
        check1("starve_grant_cycle", 128'(first_i), 128'(SMAX));
        check1("starve_then_data", 128'(d_after), 128'(1));
        cyc(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), o);

        // Full FIFO, then accept alongside a response.
        all_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(vi(0, 1, 32'h1c000200 + 32'(4 * k), 0, 0, 0, 0,
                   1, 0, 0), o);
            all_ok = all_ok & o.iaok;
        end
        check1("fill_4_accepts", 128'(all_ok), 128'(1));
        cyc(vi(0, 1, 32'h1c000210, 0, 0, 0, 0, 1, 0, 0), o);
        check1("full_blocks", {o.mreq, o.iaok}, 2'b00);
        cyc(vi(0, 1, 32'h1c000210, 0, 0, 0, 0, 1, 1, 32'hf00d0000), o);
        check1("full_push_pop", {o.mreq, o.iaok, o.idok, o.irdata},
               {3'b111, 32'hf00d0000});
        cyc(vi(0, 1, 32'h1c000214, 0, 0, 0, 0, 1, 0, 0), o);
        check1("still_full", {o.mreq, o.iaok}, 2'b00);
        for (int k = 0; k < 4; k++) cyc(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), o);

        // Response ordering across owners.
        cyc(vi(0, 1, 32'h1c000300, 0, 0, 0, 0, 1, 0, 0), o);
        cyc(vi(0, 0, 0, 1, 0, 0, 32'h1c008300, 1, 0, 0), o);
        cyc(vi(0, 1, 32'h1c000304, 0, 0, 0, 0, 1, 0, 0), o);
        cyc(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'ha), o);
        check1("ord_a", {o.idok, o.irdata, o.ddok, o.drdata},
               {1'b1, 32'ha, 1'b0, 32'h0});
        cyc(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hb), o);
        check1("ord_b", {o.idok, o.irdata, o.ddok, o.drdata},
               {1'b0, 32'h0, 1'b1, 32'hb});
        cyc(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hc), o);
        check1("ord_c", {o.idok, o.irdata, o.ddok, o.drdata},
               {1'b1, 32'hc, 1'b0, 32'h0});

        // Reset with two in flight discards their tags.
        cyc(vi(0, 1, 32'h1c000400, 0, 0, 0, 0, 1, 0, 0), o);
        cyc(vi(0, 1, 32'h1c000404, 0, 0, 0, 0, 1, 0, 0), o);
        cyc(vi(1, 1, 32'h1c000408, 1, 0, 0, 32'h1c008400, 1, 0, 0), o);
        check1("rst_outputs", {o.mreq, o.iaok, o.daok, o.idok, o.ddok},
               5'b0);
        all_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(vi(0, 1, 32'h1c000500 + 32'(4 * k), 0, 0, 0, 0,
                   1, 0, 0), o);
            all_ok = all_ok & o.iaok;
        end
        check1("rst_fifo_empty", 128'(all_ok), 128'(1));
        cyc(vi(0, 1, 32'h1c000510, 0, 0, 0, 0, 1, 0, 0), o);
        check1("rst_then_full", {o.mreq, o.iaok}, 2'b00);
        all_ok = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cyc(vi(0, 0, 0, 0, 0, 0, 0, 0, 1, 32'(k)), o);
            all_ok = all_ok & o.idok & (o.irdata == 32'(k));
        end
        check1("rst_drain", 128'(all_ok), 128'(1));

        // Random traffic against the reference model.
        held = -1; starve = 0; q.delete();
        ip = 1'b0; dp = 1'b0;
        ia = 0; da = 0; dd = 0; ds = 0; dst = 0; dwr_r = 0;
        for (int c = 0; c < 3000; c++) begin
            in_t  v;
            out_t e;
            if (!ip && $urandom_range(2) == 0) begin
                ip = 1'b1;
                ia = $urandom & 32'hffff_fffc;
            end
            if (!dp && $urandom_range(1) == 0) begin
                dp = 1'b1;
                da = $urandom;
                dd = $urandom;
                dwr_r = 1'($urandom_range(1));
                ds = 2'($urandom_range(2));
                dst = 4'($urandom_range(15));
            end
            v = idle;
            v.rst = (c == 0) || ($urandom_range(199) == 0);
            v.ireq = ip; v.iaddr = ia;
            v.dreq = dp; v.dwr = dwr_r; v.dsize = ds;
            v.dstrb = dst; v.daddr = da; v.dwdata = dd;
            v.maok = ($urandom_range(3) != 0);
            v.mdok = (q.size() > 0) && ($urandom_range(1) == 1);
            v.mrdata = $urandom;

            e = '0;
            if (v.rst) begin
                q.delete(); held = -1; starve = 0;
            end else begin
                pop = v.mdok && q.size() > 0;
                room = (q.size() < OUT) || pop;
                win = -1;
                if (held >= 0) win = held;
                else if (room) begin
                    if (v.ireq && (!v.dreq || starve == SMAX)) win = 0;
                    else if (v.dreq) win = 1;
                end
                if (win == 0) begin
                    e.mreq = 1; e.msize = 2'd2; e.maddr = v.iaddr;
                    e.iaok = v.maok;
                end else if (win == 1) begin
                    e.mreq = 1; e.mwr = v.dwr; e.msize = v.dsize;
                    e.mwstrb = v.dstrb; e.maddr = v.daddr;
                    e.mwdata = v.dwdata; e.daok = v.maok;
                end
                if (pop) begin
                    if (q[0] == 0) begin
                        e.idok = 1; e.irdata = v.mrdata;
                    end else begin
                        e.ddok = 1; e.drdata = v.mrdata;
                    end
                    void'(q.pop_front());
                end
                if (win >= 0 && v.maok) q.push_back(win);
                held = (win >= 0 && !v.maok) ? win : -1;
                if (!v.ireq || (win == 0 && v.maok)) starve = 0;
                else if (starve < SMAX) starve++;
            end

            cyc(v, o);
            check($sformatf("rand%0d", c), o, e);
            if (e.iaok) ip = 1'b0;
            if (e.daok) dp = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
